// File: rtl/fpu_fp64_pkg.sv
// Shared FP64 constants, int64 limits and the converter FSM state type.
package fpu_fp64_pkg;

    localparam int unsigned FP64_EXP_BIAS = 1023;
    localparam int unsigned FP64_FRAC_W   = 52;
    localparam logic [10:0] FP64_EXP_MAX  = 11'h7FF;

    // Biased exponent of 2^63: anything at or above this no longer fits in int64.
    localparam logic [10:0] FP64_EXP_SAT  = 11'(FP64_EXP_BIAS + 63);

    localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN,
        DONE
    } ftoi_state_e;

    // Log-shifter stage width for stage index 0..5 -> 32,16,8,4,2,1.
    function automatic logic [5:0] stage_width(input logic [2:0] idx);
        return 6'd32 >> idx;
    endfunction

endpackage

// File: rtl/fpu_fp64_ftoi_if.sv
// Request/response bundle of the FP64 -> int64 converter.
interface fpu_fp64_ftoi_if;

    logic        start;
    logic [63:0] srca;
    logic        busy;
    logic        done;
    logic [63:0] dst;
    logic        fInvalid;
    logic        fOverflow;

    modport master (
        output start,
        output srca,
        input  busy,
        input  done,
        input  dst,
        input  fInvalid,
        input  fOverflow
    );

    modport slave (
        input  start,
        input  srca,
        output busy,
        output done,
        output dst,
        output fInvalid,
        output fOverflow
    );

endinterface

// File: rtl/fpu_fp64_shr_stage.sv
// One stage of the iterative log shifter used by the FP64 -> int64 converter.
// Optional macro FPU_FTOI_ROUND_EN adds guard/sticky tracking for round-to-nearest-even;
// without it those ports and their logic do not exist.
module fpu_fp64_shr_stage (
    input  logic [63:0] value,
    input  logic [5:0]  width,
    input  logic        enable,
    input  logic        left,
`ifdef FPU_FTOI_ROUND_EN
    input  logic        guard,
    input  logic        sticky,
    output logic        guard_nxt,
    output logic        sticky_nxt,
`endif
    output logic [63:0] value_nxt
);

`ifdef FPU_FTOI_ROUND_EN
    // Bits below the new guard position fold into sticky.
    logic [63:0] low_mask;
    assign low_mask = (64'd1 << (width - 6'd1)) - 64'd1;
`endif

    // Apply the shift when this stage's amount bit is set; left shifts leave guard/sticky alone.
    always_comb begin
        value_nxt = value;
`ifdef FPU_FTOI_ROUND_EN
        guard_nxt  = guard;
        sticky_nxt = sticky;
`endif
        if (enable) begin
            if (left) begin
                value_nxt = value << width;
            end else begin
`ifdef FPU_FTOI_ROUND_EN
                sticky_nxt = sticky | guard | (|(value & low_mask));
                guard_nxt  = value[width - 6'd1];
`endif
                value_nxt  = value >> width;
            end
        end
    end

endmodule

// File: rtl/fpu_fp64_ftoi.sv
// Multi-cycle FP64 -> signed int64 converter (truncating by default).
// Defining FPU_FTOI_ROUND_EN switches the final step to round-to-nearest-even.
// Latency is fixed: done is high in the 8th cycle after the accepting edge.
module fpu_fp64_ftoi
    import fpu_fp64_pkg::*;
#(
    parameter logic [63:0] NAN_RESULT = 64'h8000_0000_0000_0000
) (
    input  logic clk,
    input  logic reset,
    fpu_fp64_ftoi_if.slave bus
);

    ftoi_state_e state, state_nxt;

    logic [2:0]  stage_idx;
    logic [63:0] work;
    logic [5:0]  amount;
    logic        shift_left;
    logic        sign;
    logic [10:0] exp;
    logic        frac_nz;

    logic [63:0] dst_q;
    logic        invalid_q;
    logic        overflow_q;

    logic        busy;
    logic        done;

`ifdef FPU_FTOI_ROUND_EN
    logic        guard;
    logic        sticky;
    logic        guard_nxt;
    logic        sticky_nxt;
`endif

    // Operand decode at the accepting edge.
    logic signed [11:0] unb_exp;
    logic               load_left;
    logic [5:0]         load_amount;

    assign unb_exp   = $signed({1'b0, bus.srca[62:52]}) - 12'sd1023;
    assign load_left = (unb_exp >= 12'sd52);

    // Right shifts beyond 63 already flush the mantissa, so clamp the amount.
    always_comb begin
        if (load_left) begin
            load_amount = 6'(unb_exp - 12'sd52);
        end else if ((12'sd52 - unb_exp) > 12'sd63) begin
            load_amount = 6'd63;
        end else begin
            load_amount = 6'(12'sd52 - unb_exp);
        end
    end

    logic [5:0]  stage_w;
    logic        stage_en;
    logic [63:0] stage_value;

    assign stage_w  = stage_width(stage_idx);
    assign stage_en = amount[3'd5 - stage_idx];

    fpu_fp64_shr_stage u_stage (
        .value     (work),
        .width     (stage_w),
        .enable    (stage_en),
        .left      (shift_left),
`ifdef FPU_FTOI_ROUND_EN
        .guard     (guard),
        .sticky    (sticky),
        .guard_nxt (guard_nxt),
        .sticky_nxt(sticky_nxt),
`endif
        .value_nxt (stage_value)
    );

    // Final magnitude, optional rounding, sign, saturation and flags.
    logic [63:0] mag;
    logic [63:0] sat_value;
    logic [63:0] fin_dst;
    logic        fin_invalid;
    logic        fin_overflow;

`ifdef FPU_FTOI_ROUND_EN
    assign mag = work + {63'd0, guard & (sticky | work[0])};
`else
    assign mag = work;
`endif
    assign sat_value = sign ? INT64_MIN : INT64_MAX;

    // Special cases in priority order, then the plain signed magnitude.
    always_comb begin
        fin_dst      = 64'd0;
        fin_invalid  = 1'b0;
        fin_overflow = 1'b0;
        if (exp == FP64_EXP_MAX && frac_nz) begin
            fin_dst     = NAN_RESULT;
            fin_invalid = 1'b1;
        end else if (exp == FP64_EXP_MAX) begin
            fin_dst     = sat_value;
            fin_invalid = 1'b1;
        end else if (exp >= FP64_EXP_SAT) begin
            if (sign && exp == FP64_EXP_SAT && !frac_nz) begin
                // -2^63 is the one value at this exponent that fits exactly.
                fin_dst = INT64_MIN;
            end else begin
                fin_dst      = sat_value;
                fin_overflow = 1'b1;
            end
        end else if (exp == 11'd0) begin
            fin_dst = 64'd0;
`ifdef FPU_FTOI_ROUND_EN
        end else if (mag[63] && !sign) begin
            // Rounding carried into bit 63 for a positive operand.
            fin_dst      = INT64_MAX;
            fin_overflow = 1'b1;
`endif
        end else begin
            fin_dst = sign ? (~mag + 64'd1) : mag;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (stage_idx == 3'd5) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift one stage per cycle, commit results in FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_idx  <= 3'd0;
            work       <= 64'd0;
            amount     <= 6'd0;
            shift_left <= 1'b0;
            sign       <= 1'b0;
            exp        <= 11'd0;
            frac_nz    <= 1'b0;
            dst_q      <= 64'd0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef FPU_FTOI_ROUND_EN
            guard      <= 1'b0;
            sticky     <= 1'b0;
`endif
        end else begin
            if (state == IDLE && bus.start) begin
                stage_idx  <= 3'd0;
                work       <= {11'd0, 1'b1, bus.srca[51:0]};
                amount     <= load_amount;
                shift_left <= load_left;
                sign       <= bus.srca[63];
                exp        <= bus.srca[62:52];
                frac_nz    <= |bus.srca[51:0];
`ifdef FPU_FTOI_ROUND_EN
                guard      <= 1'b0;
                sticky     <= 1'b0;
`endif
            end
            if (state == SHIFT) begin
                work      <= stage_value;
                stage_idx <= stage_idx + 3'd1;
`ifdef FPU_FTOI_ROUND_EN
                guard     <= guard_nxt;
                sticky    <= sticky_nxt;
`endif
            end
            if (state == FIN) begin
                dst_q      <= fin_dst;
                invalid_q  <= fin_invalid;
                overflow_q <= fin_overflow;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.dst       = dst_q;
    assign bus.fInvalid  = invalid_q;
    assign bus.fOverflow = overflow_q;

endmodule
